mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_pkg.sv | 58 +++++
 rtl/mc_controller_if.sv | 36 +++
 rtl/mc_defs.vh | 40 ++++
 rtl/mem_watchdog.sv | 33 +++
 rtl/mc_controller.sv | 158 +++++++++++++++
 tb/tb_mc_controller.sv | 164 ++++++++++++++++
 6 files changed

// File: rtl/mc_controller_pkg.sv
// Types and encodings for the multi-cycle controller; values track mc_defs.vh.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ORIEX  = 4'd9,
    S_ORIWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_SIMM = 2'b10;
  localparam logic [1:0] SRCB_ZIMM = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_wrt;
    logic       pc_wrt_cond;
    logic       i_or_d;
    logic       ir_wrt;
    logic       mem_read;
    logic       mem_wrt;
    logic       mem_reg;
    logic       reg_dst;
    logic       reg_wrt;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal;
    logic       timeout;
  } ctrl_t;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath signal bundle; slave = controller side.
interface mc_controller_if;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_wrt;
  logic       pc_wrt_cond;
  logic       i_or_d;
  logic       ir_wrt;
  logic       mem_read;
  logic       mem_wrt;
  logic       mem_reg;
  logic       reg_dst;
  logic       reg_wrt;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic [3:0] state;
  logic       illegal;
  logic       timeout;

  modport slave (
    input  op, zero, mem_ready,
    output pc_wrt, pc_wrt_cond, i_or_d, ir_wrt, mem_read, mem_wrt, mem_reg,
           reg_dst, reg_wrt, alu_src_a, alu_src_b, alu_op, pc_src, state,
           illegal, timeout
  );

  modport master (
    output op, zero, mem_ready,
    input  pc_wrt, pc_wrt_cond, i_or_d, ir_wrt, mem_read, mem_wrt, mem_reg,
           reg_dst, reg_wrt, alu_src_a, alu_src_b, alu_op, pc_src, state,
           illegal, timeout
  );
endinterface

// File: rtl/mc_defs.vh
// Shared state codes, opcodes and control-field encodings for mc_controller
// and the legacy instruction decoder.
`ifndef MC_DEFS_VH
`define MC_DEFS_VH

`define MC_S_FETCH   4'd0
`define MC_S_DECODE  4'd1
`define MC_S_MEMADR  4'd2
`define MC_S_MEMRD   4'd3
`define MC_S_MEMWB   4'd4
`define MC_S_MEMWR   4'd5
`define MC_S_EXEC    4'd6
`define MC_S_ALUWB   4'd7
`define MC_S_BRANCH  4'd8
`define MC_S_ORIEX   4'd9
`define MC_S_ORIWB   4'd10
`define MC_S_JUMP    4'd11

`define MC_OP_RTYPE  6'b000000
`define MC_OP_LW     6'b100011
`define MC_OP_SW     6'b101011
`define MC_OP_BEQ    6'b000100
`define MC_OP_ORI    6'b001101
`define MC_OP_J      6'b000010

`define MC_ALU_ADD   2'b00
`define MC_ALU_SUB   2'b01
`define MC_ALU_FUNCT 2'b10
`define MC_ALU_OR    2'b11

`define MC_SRCB_REGB 2'b00
`define MC_SRCB_FOUR 2'b01
`define MC_SRCB_SIMM 2'b10
`define MC_SRCB_ZIMM 2'b11

`define MC_PC_ALU    2'b00
`define MC_PC_ALUOUT 2'b01
`define MC_PC_JUMP   2'b10

`endif

// File: rtl/mem_watchdog.sv
// Counts consecutive not-ready cycles in a memory wait state; expire fires on
// the MEM_TIMEOUT-th one unless ready arrives in that same cycle.
module mem_watchdog #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  output logic expire
);

  logic [7:0] cnt_q, cnt_d;

  // Leaving a wait state only happens via ready, expire or reset, so those
  // plus !active cover every state change.
  always_comb begin
    expire = active && !ready && (cnt_q == 8'(MEM_TIMEOUT - 1));
    cnt_d  = cnt_q + 8'd1;
    if (!active || ready || expire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle CPU control FSM with memory watchdog.
// Optional: define MC_JUMP_EN to enable the J instruction (state JUMP).
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst,
  mc_controller_if.slave bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl, ctrl_o;
  logic   wd_active, wd_expire;

  assign wd_active = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                     (state_q == S_MEMWR);

  mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .active (wd_active),
    .ready  (bus.mem_ready),
    .expire (wd_expire)
  );

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_ALU;
        ctrl.ir_wrt    = bus.mem_ready;
        ctrl.pc_wrt    = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_SIMM;
        ctrl.alu_op    = ALU_ADD;
        case (bus.op)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ORI:       state_d = S_ORIEX;
`ifdef MC_JUMP_EN
          OP_J:         state_d = S_JUMP;
`else
          OP_J: begin
            ctrl.illegal = 1'b1;
            state_d      = S_FETCH;
          end
`endif
          default: begin
            ctrl.illegal = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SIMM;
        ctrl.alu_op    = ALU_ADD;
        state_d        = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.reg_wrt = 1'b1;
        ctrl.mem_reg = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_wrt = 1'b1;
        ctrl.i_or_d  = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALU_FUNCT;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_wrt = 1'b1;
        ctrl.reg_dst = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SRCB_REGB;
        ctrl.alu_op      = ALU_SUB;
        ctrl.pc_src      = PC_ALUOUT;
        ctrl.pc_wrt_cond = bus.zero;
        state_d          = S_FETCH;
      end
      S_ORIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_ZIMM;
        ctrl.alu_op    = ALU_OR;
        state_d        = S_ORIWB;
      end
      S_ORIWB: begin
        ctrl.reg_wrt = 1'b1;
        state_d      = S_FETCH;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        ctrl.pc_wrt = 1'b1;
        ctrl.pc_src = PC_JUMP;
        state_d     = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Expiry implies mem_ready=0, so ir_wrt/pc_wrt are already low here.
    if (wd_expire) begin
      ctrl.timeout = 1'b1;
      state_d      = S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset masks every output in the cycle it is sampled, not just the next.
  assign ctrl_o = rst ? '0 : ctrl;

  assign bus.pc_wrt      = ctrl_o.pc_wrt;
  assign bus.pc_wrt_cond = ctrl_o.pc_wrt_cond;
  assign bus.i_or_d      = ctrl_o.i_or_d;
  assign bus.ir_wrt      = ctrl_o.ir_wrt;
  assign bus.mem_read    = ctrl_o.mem_read;
  assign bus.mem_wrt     = ctrl_o.mem_wrt;
  assign bus.mem_reg     = ctrl_o.mem_reg;
  assign bus.reg_dst     = ctrl_o.reg_dst;
  assign bus.reg_wrt     = ctrl_o.reg_wrt;
  assign bus.alu_src_a   = ctrl_o.alu_src_a;
  assign bus.alu_src_b   = ctrl_o.alu_src_b;
  assign bus.alu_op      = ctrl_o.alu_op;
  assign bus.pc_src      = ctrl_o.pc_src;
  assign bus.illegal     = ctrl_o.illegal;
  assign bus.timeout     = ctrl_o.timeout;
  assign bus.state       = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller (MEM_TIMEOUT=4).
module tb_mc_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mc_controller_if bus();

  mc_controller #(.MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {pc_wrt,pc_wrt_cond,i_or_d,ir_wrt,mem_read,mem_wrt,mem_reg,reg_dst,reg_wrt,
  //  alu_src_a,alu_src_b[2],alu_op[2],pc_src[2],illegal,timeout}
  logic [17:0] ctrl;
  assign ctrl = {bus.pc_wrt, bus.pc_wrt_cond, bus.i_or_d, bus.ir_wrt,
                 bus.mem_read, bus.mem_wrt, bus.mem_reg, bus.reg_dst,
                 bus.reg_wrt, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                 bus.pc_src, bus.illegal, bus.timeout};

  localparam logic [17:0] C_NONE   = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_FETCHR = 18'b1_0_0_1_1_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_FETCHW = 18'b0_0_0_0_1_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_DECODE = 18'b0_0_0_0_0_0_0_0_0_0_10_00_00_0_0;
  localparam logic [17:0] C_DECILL = 18'b0_0_0_0_0_0_0_0_0_0_10_00_00_1_0;
  localparam logic [17:0] C_MEMADR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_MEMRD  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MEMWB  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_0;
  localparam logic [17:0] C_MEMWR  = 18'b0_0_1_0_0_1_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MEMWRT = 18'b0_0_1_0_0_1_0_0_0_0_00_00_00_0_1;
  localparam logic [17:0] C_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] C_ALUWB  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_0;
  localparam logic [17:0] C_BRZ1   = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_0;
  localparam logic [17:0] C_BRZ0   = 18'b0_0_0_0_0_0_0_0_0_1_00_01_01_0_0;
  localparam logic [17:0] C_ORIEX  = 18'b0_0_0_0_0_0_0_0_0_1_11_11_00_0_0;
  localparam logic [17:0] C_ORIWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_0;
  localparam logic [17:0] C_JUMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_0;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] ORI = 6'b001101;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, then check that cycle's outputs.
  task automatic cyc(input string tag, input logic [5:0] op, input logic z,
                     input logic rdy, input logic [3:0] st, input logic [17:0] c);
    @(negedge clk);
    rst           = 1'b0;
    bus.op        = op;
    bus.zero      = z;
    bus.mem_ready = rdy;
    #1;
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".ctrl"}, 32'(ctrl), 32'(c));
  endtask

  initial begin
    bus.op = BAD; bus.zero = 1'b1; bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.state", 32'(bus.state), 32'd0);
    chk("rst.ctrl", 32'(ctrl), 32'(C_NONE));

    cyc("lw0", LW, 0, 1, 4'd0, C_FETCHR);
    chk("wd_after_rst", 32'(dut.u_wdog.cnt_q), 32'd0);
    cyc("lw1", LW, 0, 1, 4'd1, C_DECODE);
    cyc("lw2", LW, 0, 1, 4'd2, C_MEMADR);
    cyc("lw3", LW, 0, 1, 4'd3, C_MEMRD);
    cyc("lw4", LW, 0, 1, 4'd4, C_MEMWB);

    cyc("sw0", SW, 0, 1, 4'd0, C_FETCHR);
    cyc("sw1", SW, 0, 1, 4'd1, C_DECODE);
    cyc("sw2", SW, 0, 1, 4'd2, C_MEMADR);
    cyc("sw5", SW, 0, 1, 4'd5, C_MEMWR);

    cyc("rt0", RT, 0, 1, 4'd0, C_FETCHR);
    cyc("rt1", RT, 0, 1, 4'd1, C_DECODE);
    cyc("rt6", RT, 0, 1, 4'd6, C_EXEC);
    cyc("rt7", RT, 0, 1, 4'd7, C_ALUWB);

    cyc("ori0", ORI, 0, 1, 4'd0, C_FETCHR);
    cyc("ori1", ORI, 0, 1, 4'd1, C_DECODE);
    cyc("ori9", ORI, 0, 1, 4'd9, C_ORIEX);
    cyc("ori10", ORI, 0, 1, 4'd10, C_ORIWB);

    cyc("beqz0", BEQ, 1, 1, 4'd0, C_FETCHR);
    cyc("beqz1", BEQ, 1, 1, 4'd1, C_DECODE);
    cyc("beqz8", BEQ, 1, 1, 4'd8, C_BRZ1);
    cyc("beqn0", BEQ, 0, 1, 4'd0, C_FETCHR);
    cyc("beqn1", BEQ, 0, 1, 4'd1, C_DECODE);
    cyc("beqn8", BEQ, 0, 1, 4'd8, C_BRZ0);

    cyc("ill0", BAD, 0, 1, 4'd0, C_FETCHR);
    cyc("ill1", BAD, 0, 1, 4'd1, C_DECILL);

    cyc("j0", JMP, 0, 1, 4'd0, C_FETCHR);
`ifdef MC_JUMP_EN
    cyc("j1", JMP, 0, 1, 4'd1, C_DECODE);
    cyc("j11", JMP, 0, 1, 4'd11, C_JUMP);
`else
    cyc("j1", JMP, 0, 1, 4'd1, C_DECILL);
`endif

    // Fetch wait state adds one cycle.
    cyc("fw0", RT, 0, 0, 4'd0, C_FETCHW);
    cyc("fw1", RT, 0, 1, 4'd0, C_FETCHR);
    cyc("fw2", RT, 0, 1, 4'd1, C_DECODE);
    cyc("fw6", RT, 0, 1, 4'd6, C_EXEC);
    cyc("fw7", RT, 0, 1, 4'd7, C_ALUWB);

    // SW stalls in MEMWR until the watchdog fires on the 4th wait cycle.
    cyc("to0", SW, 0, 1, 4'd0, C_FETCHR);
    cyc("to1", SW, 0, 1, 4'd1, C_DECODE);
    cyc("to2", SW, 0, 1, 4'd2, C_MEMADR);
    cyc("to_w1", SW, 0, 0, 4'd5, C_MEMWR);
    cyc("to_w2", SW, 0, 0, 4'd5, C_MEMWR);
    cyc("to_w3", SW, 0, 0, 4'd5, C_MEMWR);
    cyc("to_w4", SW, 0, 0, 4'd5, C_MEMWRT);
    cyc("to_fetch", SW, 0, 1, 4'd0, C_FETCHR);
    chk("wd_after_to", 32'(dut.u_wdog.cnt_q), 32'd0);

    // Ready on the 4th wait cycle wins over expiry.
    cyc("rdy1", SW, 0, 1, 4'd1, C_DECODE);
    cyc("rdy2", SW, 0, 1, 4'd2, C_MEMADR);
    cyc("rdy_w1", SW, 0, 0, 4'd5, C_MEMWR);
    cyc("rdy_w2", SW, 0, 0, 4'd5, C_MEMWR);
    cyc("rdy_w3", SW, 0, 0, 4'd5, C_MEMWR);
    cyc("rdy_w4", SW, 0, 1, 4'd5, C_MEMWR);
    cyc("rdy_fetch", LW, 0, 1, 4'd0, C_FETCHR);

    // Reset in MEMRD of an LW, after the watchdog has started counting.
    cyc("rr1", LW, 0, 1, 4'd1, C_DECODE);
    cyc("rr2", LW, 0, 1, 4'd2, C_MEMADR);
    cyc("rr3a", LW, 0, 0, 4'd3, C_MEMRD);
    cyc("rr3b", LW, 0, 0, 4'd3, C_MEMRD);
    rst = 1'b1;
    #1;
    chk("rr_rst.state", 32'(bus.state), 32'd0);
    chk("rr_rst.ctrl", 32'(ctrl), 32'(C_NONE));
    cyc("rr_fetch", LW, 0, 0, 4'd0, C_FETCHW);
    chk("wd_after_rr", 32'(dut.u_wdog.cnt_q), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
